// File: rtl/add_multiply_pkg.sv
// Shared definitions for the add_multiply_acc pre-add / multiply / accumulate unit:
// operation codes and the derived width helpers.
package add_multiply_pkg;

    localparam logic [1:0] MODE_LOAD_ADD = 2'b00;
    localparam logic [1:0] MODE_LOAD_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC_ADD  = 2'b10;
    localparam logic [1:0] MODE_ACC_SUB  = 2'b11;

    // Exact (A+/-B)*C needs one extra bit for the pre-add on top of the 2*WIDTH product.
    function automatic int calc_prod_w(input int width);
        return 32'sd2 * width + 32'sd1;
    endfunction

    function automatic int calc_y_w(input int width, input int acc_guard);
        return calc_prod_w(width) + acc_guard;
    endfunction

endpackage

// File: rtl/add_multiply_acc_stage.sv
// Final pipeline stage: loads or accumulates the product into Y, with a sticky
// two's-complement overflow flag that any LOAD clears.
module add_multiply_acc_stage
    import add_multiply_pkg::*;
#(
    parameter int PROD_W = 31,
    parameter int Y_W    = 39
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     valid_i,
    input  logic [1:0]               mode_i,
    input  logic signed [PROD_W-1:0] prod_i,
    output logic signed [Y_W-1:0]    y_o,
    output logic                     valid_o,
    output logic                     overflow_o
);

    logic signed [Y_W-1:0] y_q;
    logic signed [Y_W-1:0] y_d;
    logic                  valid_q;
    logic                  valid_d;
    logic                  ovf_q;
    logic                  ovf_d;
    logic signed [Y_W-1:0] prod_ext_s;
    logic signed [Y_W:0]   acc_s;

    // Next accumulator value; one extra bit exposes signed overflow as a top-two-bit mismatch.
    always_comb begin
        prod_ext_s = Y_W'(prod_i);
        acc_s      = '0;
        y_d        = y_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        if (valid_i) begin
            valid_d = 1'b1;
            case (mode_i)
                MODE_LOAD_ADD, MODE_LOAD_SUB: begin
                    y_d   = prod_ext_s;
                    ovf_d = 1'b0;
                end
                MODE_ACC_ADD: begin
                    acc_s = (Y_W+1)'(y_q) + (Y_W+1)'(prod_ext_s);
                    y_d   = acc_s[Y_W-1:0];
                    ovf_d = ovf_q | (acc_s[Y_W] ^ acc_s[Y_W-1]);
                end
                MODE_ACC_SUB: begin
                    acc_s = (Y_W+1)'(y_q) - (Y_W+1)'(prod_ext_s);
                    y_d   = acc_s[Y_W-1:0];
                    ovf_d = ovf_q | (acc_s[Y_W] ^ acc_s[Y_W-1]);
                end
                default: begin
                    y_d   = y_q;
                    ovf_d = ovf_q;
                end
            endcase
        end else begin
            y_d     = y_q;
            ovf_d   = ovf_q;
            valid_d = 1'b0;
        end
    end

    // Accumulator, result-valid and sticky overflow registers, frozen while ce is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (ce) begin
            y_q     <= y_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign y_o        = y_q;
    assign valid_o    = valid_q & ce;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/add_multiply_acc.sv
// Pipelined signed (A+/-B)*C unit with optional running accumulation into Y.
// S1 input capture, S2 pre-add, S3 multiply, S4 accumulate (sub-module).
module add_multiply_acc
    import add_multiply_pkg::*;
#(
    parameter int  WIDTH     = 15,
    parameter int  ACC_GUARD = 8,
    localparam int PROD_W    = calc_prod_w(WIDTH),
    localparam int Y_W       = calc_y_w(WIDTH, ACC_GUARD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic [1:0]              mode,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    input  logic signed [WIDTH-1:0] C,
    output logic signed [Y_W-1:0]   Y,
    output logic                    out_valid,
    output logic                    overflow
);

    logic signed [WIDTH-1:0]  a1_q;
    logic signed [WIDTH-1:0]  b1_q;
    logic signed [WIDTH-1:0]  c1_q;
    logic [1:0]               mode1_q;
    logic                     vld1_q;
    logic signed [WIDTH:0]    sum2_q;
    logic signed [WIDTH:0]    sum2_d;
    logic signed [WIDTH-1:0]  c2_q;
    logic [1:0]               mode2_q;
    logic                     vld2_q;
    logic signed [PROD_W-1:0] prod3_q;
    logic signed [PROD_W-1:0] prod3_d;
    logic [1:0]               mode3_q;
    logic                     vld3_q;

    // Only LOAD_SUB subtracts in the pre-adder; ACC_SUB subtracts (A+B)*C at the accumulator.
    always_comb begin
        sum2_d = '0;
        if (mode1_q == MODE_LOAD_SUB) begin
            sum2_d = (WIDTH+1)'(a1_q) - (WIDTH+1)'(b1_q);
        end else begin
            sum2_d = (WIDTH+1)'(a1_q) + (WIDTH+1)'(b1_q);
        end
        prod3_d = PROD_W'(sum2_q) * PROD_W'(c2_q);
    end

    // S1..S3 pipeline registers; mode and valid travel with their data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q    <= '0;
            b1_q    <= '0;
            c1_q    <= '0;
            mode1_q <= 2'b00;
            vld1_q  <= 1'b0;
            sum2_q  <= '0;
            c2_q    <= '0;
            mode2_q <= 2'b00;
            vld2_q  <= 1'b0;
            prod3_q <= '0;
            mode3_q <= 2'b00;
            vld3_q  <= 1'b0;
        end else if (ce) begin
            a1_q    <= A;
            b1_q    <= B;
            c1_q    <= C;
            mode1_q <= mode;
            vld1_q  <= in_valid;
            sum2_q  <= sum2_d;
            c2_q    <= c1_q;
            mode2_q <= mode1_q;
            vld2_q  <= vld1_q;
            prod3_q <= prod3_d;
            mode3_q <= mode2_q;
            vld3_q  <= vld2_q;
        end
    end

    add_multiply_acc_stage #(
        .PROD_W (PROD_W),
        .Y_W    (Y_W)
    ) u_acc_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .valid_i    (vld3_q),
        .mode_i     (mode3_q),
        .prod_i     (prod3_q),
        .y_o        (Y),
        .valid_o    (out_valid),
        .overflow_o (overflow)
    );

endmodule
